// File: rtl/fpadd_seq.sv
// Sequencer in front of a multi-cycle FP adder: FIFO-buffers operand pairs, issues one at a time,
// returns results in order. Define FPADD_SEQ_TIMEOUT_EN to enable the WAIT-state timeout.
module fpadd_seq #(
  parameter int DWIDTH  = 32,
  parameter int EWIDTH  = 8,
  parameter int MWIDTH  = 23,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [DWIDTH-1:0] req_a,
  input  logic [DWIDTH-1:0] req_b,
  output logic              fp_valid,
  output logic [DWIDTH-1:0] fp_a,
  output logic [DWIDTH-1:0] fp_b,
  input  logic [DWIDTH-1:0] fp_sum,
  input  logic [2:0]        fp_fex,
  input  logic              fp_done,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DWIDTH-1:0] rsp_sum,
  output logic [2:0]        rsp_fex,
  output logic              rsp_err,
  output logic [15:0]       ops_done
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  // +0.0 laid out as sign/exponent/mantissa fields
  localparam logic [DWIDTH-1:0] ZERO_SUM =
    {{(DWIDTH-EWIDTH-MWIDTH){1'b0}}, {EWIDTH{1'b0}}, {MWIDTH{1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t            r_state, w_next;
  logic [DWIDTH-1:0] r_mem_a [DEPTH];
  logic [DWIDTH-1:0] r_mem_b [DEPTH];
  logic [AW-1:0]     r_wptr, r_rptr;
  logic [CW-1:0]     r_count;
  logic [DWIDTH-1:0] r_fp_a, r_fp_b, r_rsp_sum;
  logic [2:0]        r_rsp_fex;
  logic [15:0]       r_ops_done;
  logic              w_push, w_pop, w_ld_rsp, w_to;

  assign req_ready = (r_count != CW'(DEPTH));
  assign w_push    = req_valid && req_ready;
  assign w_pop     = (r_state == S_IDLE) && (r_count != '0);

  assign fp_valid  = (r_state == S_ISSUE);
  assign fp_a      = r_fp_a;
  assign fp_b      = r_fp_b;
  assign rsp_valid = (r_state == S_RESP);
  assign rsp_sum   = r_rsp_sum;
  assign rsp_fex   = r_rsp_fex;
  assign ops_done  = r_ops_done;

`ifdef FPADD_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] r_wcnt;
  logic          r_rsp_err;

  assign w_to    = (r_state == S_WAIT) && !fp_done && (r_wcnt == TW'(TIMEOUT - 1));
  assign rsp_err = r_rsp_err;

  // Counter restarts on every WAIT entry, so it only needs to run in WAIT
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wcnt    <= '0;
      r_rsp_err <= 1'b0;
    end else begin
      if (r_state == S_ISSUE)     r_wcnt <= '0;
      else if (r_state == S_WAIT) r_wcnt <= r_wcnt + TW'(1);
      if (w_ld_rsp)               r_rsp_err <= w_to;
    end
  end
`else
  logic w_unused_timeout;
  assign w_unused_timeout = ^(32'(TIMEOUT));
  assign w_to    = 1'b0;
  assign rsp_err = 1'b0;
`endif

  always_comb begin
    w_next   = r_state;
    w_ld_rsp = 1'b0;
    case (r_state)
      S_IDLE:  if (r_count != '0) w_next = S_ISSUE;
      S_ISSUE: w_next = S_WAIT;
      S_WAIT: begin
        if (fp_done || w_to) begin
          w_next   = S_RESP;
          w_ld_rsp = 1'b1;
        end
      end
      S_RESP:  if (rsp_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_a[r_wptr] <= req_a;
      r_mem_b[r_wptr] <= req_b;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_fp_a     <= '0;
      r_fp_b     <= '0;
      r_rsp_sum  <= ZERO_SUM;
      r_rsp_fex  <= 3'b000;
      r_ops_done <= 16'h0000;
    end else begin
      r_state <= w_next;
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      // Operands stay put until the next pop, covering ISSUE through WAIT exit
      if (w_pop) begin
        r_fp_a <= r_mem_a[r_rptr];
        r_fp_b <= r_mem_b[r_rptr];
      end
      if (w_ld_rsp) begin
        r_rsp_sum <= w_to ? ZERO_SUM : fp_sum;
        r_rsp_fex <= w_to ? 3'b000 : fp_fex;
      end
      if ((r_state == S_RESP) && rsp_ready) r_ops_done <= r_ops_done + 16'd1;
    end
  end

endmodule

// File: tb/tb_fpadd_seq.sv
// Directed bench for fpadd_seq with a behavioural FP-adder stub answering from a fixed table.
module tb_fpadd_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready;
  logic [31:0] req_a, req_b;
  logic        fp_valid;
  logic [31:0] fp_a, fp_b, fp_sum;
  logic [2:0]  fp_fex;
  logic        fp_done;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_sum;
  logic [2:0]  rsp_fex;
  logic        rsp_err;
  logic [15:0] ops_done;

  int total = 0;
  int bad   = 0;

  // stub controls, written only by the main sequence
  int         stub_delay = 3;
  logic       stub_en    = 1'b1;
  logic       stub_kick  = 1'b0;
  logic [2:0] stub_fex   = 3'b000;

  logic [34:0] rq[$];
  int n_fpv = 0, n_rspv = 0, n_ovl = 0;

  always #5 clk = ~clk;

  fpadd_seq dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
    .fp_valid(fp_valid), .fp_a(fp_a), .fp_b(fp_b),
    .fp_sum(fp_sum), .fp_fex(fp_fex), .fp_done(fp_done),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_sum(rsp_sum),
    .rsp_fex(rsp_fex), .rsp_err(rsp_err), .ops_done(ops_done)
  );

  function automatic logic [31:0] stub_sum(input logic [31:0] a, input logic [31:0] b);
    case ({a, b})
      64'h41200000_41600000: return 32'h41C00000;
      64'h3F800000_40000000: return 32'h40400000;
      64'h42200000_42A00000: return 32'h42F00000;
      64'hC2480000_41A00000: return 32'hC1F00000;
      default:               return a + b;
    endcase
  endfunction

  initial begin
    int scnt;
    logic [31:0] sa, sb;
    scnt = -1; sa = '0; sb = '0;
    fp_done = 1'b0; fp_sum = '0; fp_fex = '0;
    forever begin
      @(posedge clk); #1;
      fp_done = 1'b0;
      if (scnt > 0) begin
        scnt--;
        if (scnt == 0) begin
          fp_done = 1'b1;
          fp_sum  = stub_sum(sa, sb);
          fp_fex  = stub_fex;
          scnt    = -1;
        end
      end
      if ((fp_valid && stub_en) || stub_kick) begin
        sa = fp_a; sb = fp_b; scnt = stub_delay;
      end
    end
  end

  always @(negedge clk) begin
    if (rsp_valid && rsp_ready) rq.push_back({rsp_fex, rsp_sum});
    if (fp_valid) n_fpv++;
    if (rsp_valid) n_rspv++;
    if (fp_valid && rsp_valid) n_ovl++;
  end

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] b);
    req_valid = 1'b1; req_a = a; req_b = b;
    tick;
    req_valid = 1'b0;
  endtask

  task automatic rst_pulse;
    req_valid = 1'b0; rst = 1'b0;
    tick;
    rst = 1'b1;
    tick;
  endtask

  function automatic logic [34:0] rq_at(input int i);
    return (i < rq.size()) ? rq[i] : '1;
  endfunction

  logic [31:0] va[6] = '{32'h40000000, 32'h40000010, 32'h40000020,
                         32'h40000030, 32'h40000040, 32'h40000050};
  logic [31:0] vb[6] = '{32'h00100000, 32'h00200000, 32'h00300000,
                         32'h00400000, 32'h00500000, 32'h00600000};
  logic [31:0] vs[6] = '{32'h40100000, 32'h40200010, 32'h40300020,
                         32'h40400030, 32'h40500040, 32'h40600050};
  logic [31:0] e30[3] = '{32'h40400000, 32'h42F00000, 32'hC1F00000};

  initial begin
    int n, base, f0, r0, idx;
    logic acc;
    rst = 1'b0; req_valid = 1'b0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
    tick; tick;
    check("rst_fp_valid", fp_valid, 0);
    check("rst_fp_a", fp_a, 0);
    check("rst_fp_b", fp_b, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_sum", rsp_sum, 0);
    check("rst_rsp_fex", rsp_fex, 0);
    check("rst_rsp_err", rsp_err, 0);
    check("rst_ops_done", ops_done, 0);
    rst = 1'b1;
    tick;
    check("rst_req_ready", req_ready, 1);

    // single op: latency and result
    rsp_ready = 1'b1;
    push(32'h41200000, 32'h41600000);
    check("t29_fpv_c1", fp_valid, 0);
    tick;
    check("t29_fpv_c2", fp_valid, 1);
    check("t29_fp_a", fp_a, 32'h41200000);
    check("t29_fp_b", fp_b, 32'h41600000);
    tick;
    check("t29_fpv_c3", fp_valid, 0);
    n = 1;
    while (!rsp_valid && n < 50) begin
      check("t29_fp_a_hold", fp_a, 32'h41200000);
      tick; n++;
    end
    check("t29_latency", n, 4);
    check("t29_rsp_sum", rsp_sum, 32'h41C00000);
    check("t29_rsp_fex", rsp_fex, 0);
    check("t29_rsp_err", rsp_err, 0);
    tick;
    check("t29_ops_done", ops_done, 1);
    check("t29_rsp_valid_drop", rsp_valid, 0);

    // three ops in order
    rst_pulse;
    base = rq.size();
    push(32'h3F800000, 32'h40000000);
    push(32'h42200000, 32'h42A00000);
    push(32'hC2480000, 32'h41A00000);
    n = 0;
    while ((rq.size() - base) < 3 && n < 200) begin tick; n++; end
    check("t30_count", rq.size() - base, 3);
    for (int i = 0; i < 3; i++) check($sformatf("t30_sum%0d", i), rq_at(base + i), {3'b000, e30[i]});
    check("t30_ops_done", ops_done, 3);

    // backpressure: FIFO fills, response held
    rst_pulse;
    rsp_ready = 1'b0; stub_fex = 3'b010;
    base = rq.size(); f0 = n_fpv; idx = 0;
    for (int c = 0; c < 10; c++) begin
      req_valid = 1'b1; req_a = va[idx]; req_b = vb[idx];
      acc = req_ready;
      tick;
      if (acc) idx++;
    end
    check("t31_accepted", idx, 5);
    check("t31_req_ready_full", req_ready, 0);
    check("t31_rsp_valid", rsp_valid, 1);
    check("t31_rsp_sum", rsp_sum, vs[0]);
    check("t31_rsp_fex", rsp_fex, 3'b010);
    tick; tick; tick;
    check("t31_rsp_sum_hold", rsp_sum, vs[0]);
    check("t31_issue_once", n_fpv - f0, 1);
    rsp_ready = 1'b1;
    tick;
    check("t31_ready_pop_full", req_ready, 0);
    tick;
    check("t31_ready_after_pop", req_ready, 1);
    tick;
    req_valid = 1'b0;
    n = 0;
    while ((rq.size() - base) < 6 && n < 300) begin tick; n++; end
    check("t31_count", rq.size() - base, 6);
    for (int i = 0; i < 6; i++) check($sformatf("t31_sum%0d", i), rq_at(base + i), {3'b010, vs[i]});
    check("t31_overlap", n_ovl, 0);
    check("t31_ops_done", ops_done, 6);

    // reset mid-WAIT abandons the op
    rst_pulse;
    stub_fex = 3'b000; stub_delay = 5;
    f0 = n_fpv;
    push(32'h3F800000, 32'h40000000);
    n = 0;
    while (!fp_valid && n < 20) begin tick; n++; end
    check("t33_issued", fp_valid, 1);
    tick; tick;
    rst = 1'b0;
    tick;
    rst = 1'b1;
    r0 = n_rspv;
    check("t33_fp_valid", fp_valid, 0);
    check("t33_fp_a", fp_a, 0);
    check("t33_fp_b", fp_b, 0);
    check("t33_rsp_valid", rsp_valid, 0);
    check("t33_rsp_sum", rsp_sum, 0);
    check("t33_rsp_err", rsp_err, 0);
    check("t33_ops_done", ops_done, 0);
    check("t33_req_ready", req_ready, 1);
    repeat (8) tick;
    check("t33_no_rsp", n_rspv - r0, 0);
    check("t33_no_reissue", n_fpv - f0, 1);
    stub_delay = 3;

`ifdef FPADD_SEQ_TIMEOUT_EN
    // timeout produces an error response; late done ignored
    rst_pulse;
    stub_en = 1'b0; rsp_ready = 1'b0;
    push(32'h41200000, 32'h41600000);
    n = 0;
    while (!fp_valid && n < 20) begin tick; n++; end
    n = 0;
    while (!rsp_valid && n < 40) begin tick; n++; end
    check("t32_latency", n, 17);
    check("t32_rsp_err", rsp_err, 1);
    check("t32_rsp_sum", rsp_sum, 0);
    check("t32_rsp_fex", rsp_fex, 0);
    stub_delay = 1; stub_kick = 1'b1;
    tick; tick;
    stub_kick = 1'b0;
    repeat (3) tick;
    check("t32_late_valid", rsp_valid, 1);
    check("t32_late_sum", rsp_sum, 0);
    check("t32_late_err", rsp_err, 1);
    rsp_ready = 1'b1;
    tick;
    check("t32_ops_done", ops_done, 1);
`else
    // without timeout, WAIT holds until fp_done arrives
    rst_pulse;
    stub_en = 1'b0; rsp_ready = 1'b1;
    push(32'h41200000, 32'h41600000);
    repeat (40) tick;
    check("t28_still_wait", rsp_valid, 0);
    stub_delay = 1; stub_kick = 1'b1;
    tick; tick;
    stub_kick = 1'b0;
    n = 0;
    while (!rsp_valid && n < 10) begin tick; n++; end
    check("t28_rsp_valid", rsp_valid, 1);
    check("t28_rsp_sum", rsp_sum, 32'h41C00000);
    check("t28_rsp_err", rsp_err, 0);
`endif
    stub_en = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fpadd_seq.md
FPADD_SEQ -- requirements
Module: fpadd_seq

Interface
REQ-001 SHALL have parameter DWIDTH, default 32, operand/result width.
REQ-002 SHALL have parameter EWIDTH, default 8, exponent width, passed through to the paired adder.
REQ-003 SHALL have parameter MWIDTH, default 23, mantissa width, passed through to the paired adder.
REQ-004 SHALL have parameter DEPTH, default 4, request FIFO entries (power of two, >=2).
REQ-005 SHALL have parameter TIMEOUT, default 16, WAIT-state cycle limit.
REQ-006 SHALL have port clk  input  1  sole clock, rising edge.
REQ-007 SHALL have port rst  input  1  reset; synchronous, active-low (one clock; reset is synchronous and active-low).
REQ-008 SHALL have ports req_valid input 1, req_ready output 1, req_a input DWIDTH, req_b input DWIDTH: upstream request handshake and operands.
REQ-009 SHALL have ports fp_valid output 1, fp_a output DWIDTH, fp_b output DWIDTH: issue side to fpadd.
REQ-010 SHALL have ports fp_sum input DWIDTH, fp_fex input 3, fp_done input 1: completion side from fpadd.
REQ-011 SHALL have ports rsp_valid output 1, rsp_ready input 1, rsp_sum output DWIDTH, rsp_fex output 3, rsp_err output 1: downstream response handshake.
REQ-012 SHALL have port ops_done output 16: count of completed responses.

Function
REQ-013 SHALL buffer requests in a DEPTH-entry FIFO; req_ready = FIFO not full; push on req_valid && req_ready.
REQ-014 SHALL decide req_ready from registered occupancy only; a same-cycle pop does not raise req_ready while full.
REQ-015 SHALL run FSM IDLE -> ISSUE -> WAIT -> RESP -> IDLE, one operation in flight at a time.
REQ-016 IDLE: if FIFO not empty, pop head, latch into fp_a/fp_b, go ISSUE; else stay.
REQ-017 ISSUE: fp_valid = 1 for exactly one cycle, then WAIT; fp_valid = 0 in all other states.
REQ-018 SHALL hold fp_a/fp_b stable from ISSUE until WAIT exits.
REQ-019 WAIT: on fp_done = 1, register fp_sum->rsp_sum, fp_fex->rsp_fex, rsp_err = 0, go RESP.
REQ-020 SHALL ignore fp_done in IDLE, ISSUE and RESP.
REQ-021 RESP: rsp_valid = 1, rsp_sum/rsp_fex/rsp_err stable; on rsp_ready go IDLE and increment ops_done (16-bit, wraps 0xFFFF->0x0000).
REQ-022 Minimum latency: fp_valid asserted in the 2nd cycle after a request is accepted into an empty FIFO in IDLE; rsp_valid in the cycle after fp_done is sampled.
REQ-023 Responses SHALL leave in request order; no request dropped or duplicated.
REQ-024 Simultaneous push and pop on a non-full FIFO: both occur, occupancy unchanged; pointers wrap modulo DEPTH.

Reset
REQ-025 With rst = 0 at a clk edge, SHALL go IDLE, empty FIFO, clear WAIT counter, and drive fp_valid=0, fp_a=0, fp_b=0, rsp_valid=0, rsp_sum=0, rsp_fex=0, rsp_err=0, ops_done=0; req_ready=1 after release.
REQ-026 Reset in any state, including mid-WAIT, SHALL abandon the operation; a later fp_done SHALL be ignored.

Configuration
REQ-027 Macro FPADD_SEQ_TIMEOUT_EN defined: WAIT counts cycles; TIMEOUT cycles without fp_done -> RESP with rsp_err=1, rsp_sum=0, rsp_fex=0; counter clears on WAIT entry.
REQ-028 Macro FPADD_SEQ_TIMEOUT_EN undefined: no counter; WAIT exits only on fp_done; rsp_err tied 0.

Verification
REQ-029 Req 0x41200000+0x41600000; stub returns 0x41C00000, fex 000, done after 3 cycles -> fp_valid one cycle, 2 cycles after accept; rsp_sum 0x41C00000, rsp_err 0, ops_done 1.
REQ-030 Requests 0x3F800000+0x40000000, 0x42200000+0x42A00000, 0xC2480000+0x41A00000; stub sums -> responses in order 0x40400000, 0x42F00000, 0xC1F00000; ops_done 3.
REQ-031 rsp_ready low, 6 back-to-back requests, DEPTH 4 -> 5 accepted, req_ready low until the first response is taken; rsp_sum stable; no fp_valid while in RESP.
REQ-032 FPADD_SEQ_TIMEOUT_EN, TIMEOUT 16, stub never done -> rsp_valid after 16 WAIT cycles, rsp_err 1, rsp_sum 0; late fp_done ignored.
REQ-033 rst low for one edge during WAIT -> all outputs zero next cycle, FIFO empty, req_ready 1; stub fp_done 2 cycles later produces no response.
